// File: rtl/blit_pkg.sv
// Shared types and constants for the sprite blitter: frame-buffer geometry,
// pixel/address widths and the FSM state encoding.
package blit_pkg;

   localparam int FB_W_DEF  = 320;
   localparam int FB_H_DEF  = 225;
   localparam int ADDR_W    = 19;
   localparam int PIX_W     = 5;
   localparam int DRAIN_CYC = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } blit_state_t;

   typedef logic [ADDR_W-1:0] fb_addr_t;
   typedef logic [PIX_W-1:0]  pix_t;

endpackage

// File: rtl/sprite_blitter_if.sv
// Blit request, source-RAM read port and frame-RAM write port of the sprite blitter.
// master: game logic plus RAM side; slave: the blitter.
interface sprite_blitter_if;
   import blit_pkg::*;

   logic       start;
   fb_addr_t   src_base;
   logic [8:0] src_w;
   logic [7:0] src_h;
   logic [8:0] dst_x;
   logic [7:0] dst_y;
   fb_addr_t   src_read_address;
   pix_t       src_data_Out;
   fb_addr_t   fb_write_address;
   pix_t       fb_data_In;
   logic       fb_we;
   logic       busy;
   logic       done;

   modport master (
      output start, src_base, src_w, src_h, dst_x, dst_y, src_data_Out,
      input  src_read_address, fb_write_address, fb_data_In, fb_we, busy, done
   );

   modport slave (
      input  start, src_base, src_w, src_h, dst_x, dst_y, src_data_Out,
      output src_read_address, fb_write_address, fb_data_In, fb_we, busy, done
   );

endinterface

// File: rtl/blit_addr_gen.sv
// Walks a sprite row-major: column/row counters, source address, destination
// row base and clip flag for the current pixel.
module blit_addr_gen
   import blit_pkg::*;
#(
   parameter int FB_W = FB_W_DEF,
   parameter int FB_H = FB_H_DEF
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_load,
   input  logic       i_step,
   input  fb_addr_t   i_src_base,
   input  logic [8:0] i_src_w,
   input  logic [7:0] i_src_h,
   input  logic [8:0] i_dst_x,
   input  logic [7:0] i_dst_y,
   output fb_addr_t   o_src_addr,
   output fb_addr_t   o_dst_addr,
   output logic       o_in_bounds,
   output logic       o_last
);

   logic [8:0] r_w;
   logic [7:0] r_h;
   logic [8:0] r_dx;
   logic [8:0] r_col;
   logic [7:0] r_row;
   logic [9:0] r_ysum;
   fb_addr_t   r_src_addr;
   fb_addr_t   r_row_base;
   logic [9:0] w_xsum;
   logic       w_row_end;

   assign w_xsum    = 10'(r_dx) + 10'(r_col);
   assign w_row_end = (r_col == r_w - 9'd1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_w        <= '0;
         r_h        <= '0;
         r_dx       <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_ysum     <= '0;
         r_src_addr <= '0;
         r_row_base <= '0;
      end else if (i_load) begin
         r_w        <= i_src_w;
         r_h        <= i_src_h;
         r_dx       <= i_dst_x;
         r_col      <= '0;
         r_row      <= '0;
         r_ysum     <= 10'(i_dst_y);
         r_src_addr <= i_src_base;
         // constant-coefficient product, reduces to shifts and adds
         r_row_base <= ADDR_W'(i_dst_y) * ADDR_W'(FB_W);
      end else if (i_step) begin
         r_src_addr <= r_src_addr + 1'b1;
         if (w_row_end) begin
            r_col      <= '0;
            r_row      <= r_row + 8'd1;
            r_ysum     <= r_ysum + 10'd1;
            r_row_base <= r_row_base + ADDR_W'(FB_W);
         end else begin
            r_col <= r_col + 9'd1;
         end
      end
   end

   assign o_src_addr  = r_src_addr;
   assign o_dst_addr  = r_row_base + ADDR_W'(w_xsum);
   assign o_in_bounds = (w_xsum < 10'(FB_W)) && (r_ysum < 10'(FB_H));
   assign o_last      = w_row_end && (r_row == r_h - 8'd1);

endmodule

// File: rtl/sprite_blitter.sv
// Copies a row-major sprite from source RAM into the frame buffer with edge clipping.
// Build option SPRITE_BLIT_TRANSPARENCY_EN: pixels equal to TRANSPARENT_IDX are not written.
//
// state | meaning
// IDLE  | waiting for start; geometry latched when start seen
// RUN   | one source read per cycle
// DRAIN | flushing the read-latency and write stages
// DONE  | one-cycle completion pulse
module sprite_blitter
   import blit_pkg::*;
#(
   parameter int   FB_W            = FB_W_DEF,
   parameter int   FB_H            = FB_H_DEF,
   parameter pix_t TRANSPARENT_IDX = 5'd0
) (
   input logic             Clk,
   input logic             Reset_n,
   sprite_blitter_if.slave bus
);

   blit_state_t r_state;
   blit_state_t w_state_nxt;
   logic [1:0]  r_drain_cnt;

   logic        w_load;
   logic        w_zero;
   logic        w_step;
   logic        w_last;
   logic        w_in_bounds;
   logic        w_opaque;
   fb_addr_t    w_src_addr;
   fb_addr_t    w_dst_addr;

   logic        r_v1;
   logic        r_inb1;
   fb_addr_t    r_dst1;
   logic        r_fb_we;
   fb_addr_t    r_fb_addr;
   pix_t        r_fb_data;

   assign w_load = (r_state == IDLE) && bus.start;
   assign w_zero = (bus.src_w == 9'd0) || (bus.src_h == 8'd0);
   assign w_step = (r_state == RUN) && !w_last;

   blit_addr_gen #(
      .FB_W (FB_W),
      .FB_H (FB_H)
   ) u_addr_gen (
      .i_clk       (Clk),
      .i_rst_n     (Reset_n),
      .i_load      (w_load),
      .i_step      (w_step),
      .i_src_base  (bus.src_base),
      .i_src_w     (bus.src_w),
      .i_src_h     (bus.src_h),
      .i_dst_x     (bus.dst_x),
      .i_dst_y     (bus.dst_y),
      .o_src_addr  (w_src_addr),
      .o_dst_addr  (w_dst_addr),
      .o_in_bounds (w_in_bounds),
      .o_last      (w_last)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state     <= IDLE;
         r_drain_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == RUN) && w_last)
            r_drain_cnt <= 2'(DRAIN_CYC - 1);
         else if ((r_state == DRAIN) && (r_drain_cnt != 2'd0))
            r_drain_cnt <= r_drain_cnt - 2'd1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (bus.start) w_state_nxt = w_zero ? DONE : RUN;
         RUN:     if (w_last) w_state_nxt = DRAIN;
         DRAIN:   if (r_drain_cnt == 2'd0) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef SPRITE_BLIT_TRANSPARENCY_EN
   assign w_opaque = (bus.src_data_Out != TRANSPARENT_IDX);
`else
   logic w_unused_tidx;
   assign w_unused_tidx = ^TRANSPARENT_IDX;
   assign w_opaque      = 1'b1;
`endif

   // stage 1 waits out the source read latency; stage 2 drives the frame RAM
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_v1      <= 1'b0;
         r_inb1    <= 1'b0;
         r_dst1    <= '0;
         r_fb_we   <= 1'b0;
         r_fb_addr <= '0;
         r_fb_data <= '0;
      end else begin
         r_v1    <= (r_state == RUN);
         r_inb1  <= w_in_bounds;
         r_dst1  <= w_dst_addr;
         r_fb_we <= r_v1 && r_inb1 && w_opaque;
         if (r_v1) begin
            r_fb_addr <= r_dst1;
            r_fb_data <= bus.src_data_Out;
         end
      end
   end

   assign bus.src_read_address = w_src_addr;
   assign bus.fb_write_address = r_fb_addr;
   assign bus.fb_data_In       = r_fb_data;
   assign bus.fb_we            = r_fb_we;
   assign bus.busy             = (r_state == RUN) || (r_state == DRAIN);
   assign bus.done             = (r_state == DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized self-checking bench for sprite_blitter; expected reads, writes and
// handshake timing come from a pixel-list model of the blit.
module tb_sprite_blitter;
   import blit_pkg::*;

   localparam int         FB_W = 320;
   localparam int         FB_H = 225;
   localparam logic [4:0] TIDX = 5'd0;

   logic Clk     = 1'b0;
   logic Reset_n = 1'b0;
   always #5 Clk = ~Clk;

   sprite_blitter_if bif();

   sprite_blitter #(
      .FB_W            (FB_W),
      .FB_H            (FB_H),
      .TRANSPARENT_IDX (TIDX)
   ) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bif)
   );

   int n_checks = 0;
   int n_errors = 0;

   function automatic logic [4:0] pix(input logic [18:0] a);
      logic [18:0] t;
      t = a * 19'd7 + (a >> 5);
      return t[4:0];
   endfunction

   // source RAM with 1-cycle read latency
   always @(posedge Clk) bif.src_data_Out <= pix(bif.src_read_address);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd"},   32'(bif.src_read_address), 32'd0);
      chk({tag, "_wa"},   32'(bif.fb_write_address), 32'd0);
      chk({tag, "_wd"},   32'(bif.fb_data_In),       32'd0);
      chk({tag, "_we"},   32'(bif.fb_we),            32'd0);
      chk({tag, "_busy"}, 32'(bif.busy),             32'd0);
      chk({tag, "_done"}, 32'(bif.done),             32'd0);
   endtask

   task automatic scramble_geom();
      bif.src_base = 19'($urandom);
      bif.src_w    = 9'($urandom_range(1, 320));
      bif.src_h    = 8'($urandom_range(1, 225));
      bif.dst_x    = 9'($urandom);
      bif.dst_y    = 8'($urandom);
   endtask

   task automatic idle_chk(input int n);
      for (int i = 0; i < n; i++) begin
         chk("idle_busy", 32'(bif.busy),  32'd0);
         chk("idle_done", 32'(bif.done),  32'd0);
         chk("idle_we",   32'(bif.fb_we), 32'd0);
         @(negedge Clk);
      end
   endtask

   // Called at a negedge; returns at the negedge of cycle N+P+4 so a following
   // call exercises back-to-back acceptance.
   task automatic run_blit(input logic [18:0] b, input int w, input int h,
                           input int x, input int y, input bit poke_busy);
      int          p;
      int          done_t;
      int          k;
      int          xs;
      int          ys;
      logic        exp_we;
      logic [18:0] sa;
      p      = w * h;
      done_t = (p == 0) ? 1 : p + 3;
      bif.src_base = b;
      bif.src_w    = 9'(w);
      bif.src_h    = 8'(h);
      bif.dst_x    = 9'(x);
      bif.dst_y    = 8'(y);
      bif.start    = 1'b1;
      @(negedge Clk);
      bif.start = 1'b0;
      scramble_geom();
      for (int t = 1; t <= done_t; t++) begin
         bif.start = poke_busy && (t == 3);
         if (poke_busy && t == 3) scramble_geom();
         chk("busy", 32'(bif.busy), 32'(p > 0 && t <= p + 2));
         chk("done", 32'(bif.done), 32'(t == done_t));
         if (t <= p) chk("rd_addr", 32'(bif.src_read_address), 32'(19'(b + 19'(t - 1))));
         k      = t - 3;
         exp_we = 1'b0;
         if (k >= 0 && k < p) begin
            xs     = x + k % w;
            ys     = y + k / w;
            sa     = 19'(b + 19'(k));
            exp_we = (xs < FB_W) && (ys < FB_H);
`ifdef SPRITE_BLIT_TRANSPARENCY_EN
            if (pix(sa) == TIDX) exp_we = 1'b0;
`endif
            if (exp_we) begin
               chk("wr_addr", 32'(bif.fb_write_address), 32'(ys * FB_W + xs));
               chk("wr_data", 32'(bif.fb_data_In),       32'(pix(sa)));
            end
         end
         chk("we", 32'(bif.fb_we), 32'(exp_we));
         @(negedge Clk);
      end
      bif.start = 1'b0;
   endtask

   initial begin
      logic [18:0] rb;
      bif.start    = 1'b0;
      bif.src_base = '0;
      bif.src_w    = '0;
      bif.src_h    = '0;
      bif.dst_x    = '0;
      bif.dst_y    = '0;
      repeat (3) @(negedge Clk);
      chk_all_zero("in_reset");
      Reset_n = 1'b1;
      @(negedge Clk);
      chk_all_zero("post_reset");

      run_blit(19'd100, 4, 3, 10, 20, 1'b0);     // basic
      run_blit(19'd40,  4, 1, 318, 0, 1'b0);     // right clip
      run_blit(19'd7,   0, 5, 3, 3, 1'b0);       // zero width
      run_blit(19'd9,   6, 0, 3, 3, 1'b0);       // zero height
      run_blit(19'd0,   2, 1, 50, 50, 1'b0);     // values {0,7}
      run_blit(19'd2000, 8, 8, 5, 5, 1'b1);      // start while busy
      idle_chk(4);
      run_blit(19'h7FFFA, 5, 3, 0, 223, 1'b0);   // source wrap, bottom clip
      run_blit(19'd3000, 320, 2, 0, 0, 1'b0);    // full width

      // reset in the middle of RUN
      bif.src_base = 19'd500;
      bif.src_w    = 9'd8;
      bif.src_h    = 8'd8;
      bif.dst_x    = 9'd0;
      bif.dst_y    = 9'd0;
      bif.start    = 1'b1;
      @(negedge Clk);
      bif.start = 1'b0;
      repeat (5) @(negedge Clk);
      chk("pre_rst_busy", 32'(bif.busy), 32'd1);
      Reset_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      repeat (2) @(negedge Clk);
      chk_all_zero("held_rst");
      Reset_n = 1'b1;
      @(negedge Clk);
      idle_chk(12);
      run_blit(19'd77, 3, 2, 100, 100, 1'b0);

      for (int i = 0; i < 40; i++) begin
         rb = ($urandom_range(0, 3) == 0) ? 19'(19'h7FFF0 + 19'($urandom_range(0, 15)))
                                          : 19'($urandom);
         run_blit(rb, $urandom_range(0, 24), $urandom_range(0, 12),
                  $urandom_range(0, 340), $urandom_range(0, 240), 1'b0);
         if ($urandom_range(0, 2) == 0) idle_chk($urandom_range(1, 3));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Copy engine on the write side of the frame buffer. On a `start` pulse it reads a rectangular sprite, row-major, from a source sprite RAM that has 1-cycle read latency. It writes each pixel into the frame-buffer RAM's write port (`write_address`/`data_In`/`we`) at a given (x, y), clipping at the screen edge. It sits between game logic, which issues blits, and the frame RAM, which the VGA path reads.

## Interface
Parameters:
- `FB_W`, 320: frame-buffer width in pixels.
- `FB_H`, 225: frame-buffer height; FB_W*FB_H = 72000 entries.
- `TRANSPARENT_IDX`, 5'd0: palette index treated as transparent (see Configuration).

Ports (one clock; reset is asynchronous and active-low):
- `Clk`  in  1  clock, all state on posedge.
- `Reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  blit request; sampled only in IDLE.
- `src_base`  in  19  sprite's first pixel address in source RAM.
- `src_w`  in  9  sprite width, 0..320.
- `src_h`  in  8  sprite height, 0..225.
- `dst_x`  in  9  destination column of sprite pixel (0,0).
- `dst_y`  in  8  destination row.
- `src_read_address`  out  19  to source RAM read port.
- `src_data_Out`  in  5  source RAM data, valid 1 cycle after address.
- `fb_write_address`  out  19  to frame RAM `write_address`.
- `fb_data_In`  out  5  to frame RAM `data_In`.
- `fb_we`  out  1  to frame RAM `we`.
- `busy`  out  1  high while a blit is in progress.
- `done`  out  1  1-cycle pulse on completion.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: if `start`, latch all geometry inputs. Go to DONE if `src_w`==0 or `src_h`==0; otherwise go to RUN with col=row=0.
- RUN: one source read per cycle. `src_read_address` = `src_base` + linear index, 19-bit, wraps mod 2^19. When col hits `src_w`-1, set col to 0 and increment row. After the read of the last pixel (row=`src_h`-1, col=`src_w`-1), go to DRAIN.
- DRAIN: 2 cycles to flush the read-latency and write pipeline stages, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Destination address = (`dst_y`+row)*FB_W + (`dst_x`+col). Keep a running row base (add FB_W per row); no multiplier.
- Clip: compute sums at 10 bits. A pixel with `dst_x`+col ≥ FB_W or `dst_y`+row ≥ FB_H is read but never written (`fb_we`=0 for that slot).
- `start` while not IDLE is ignored; the latched geometry does not change mid-blit.
- Reset, including mid-blit: go to IDLE immediately. All outputs go to 0: addresses 0, `fb_data_In` 0, `fb_we`/`busy`/`done` 0. No further writes occur.

## Timing
- Cycle N: `start` sampled in IDLE. P = `src_w`*`src_h`.
- Reads: pixel k address presented on `src_read_address` (registered) at cycle N+1+k.
- Writes: pixel k appears on `fb_*` (registered) at cycle N+3+k; the frame RAM commits it on that cycle's edge.
- Throughput: 1 pixel/cycle, no bubbles at row wrap.
- `busy`: high from N+1 through N+P+2.
- `done`: pulses at N+P+3. The next `start` is accepted at N+P+4.
- Zero-size blit: `busy` stays 0, `done` pulses at N+1, no reads or writes issued.
- `fb_we` is 0 on every cycle outside the write window.

## Configuration
- `SPRITE_BLIT_TRANSPARENCY_EN` defined: a pixel whose `src_data_Out` == `TRANSPARENT_IDX` produces `fb_we`=0 in its write slot. Timing is unchanged.
- Not defined: every in-bounds pixel is written, regardless of value; `TRANSPARENT_IDX` is unused.

## Structure
- Package `blit_pkg` holds:
  - constants `FB_W_DEF`=320, `FB_H_DEF`=225, `ADDR_W`=19, `PIX_W`=5;
  - typedef `blit_state_t` (IDLE/RUN/DRAIN/DONE);
  - typedefs `fb_addr_t` and `pix_t`.
- Sub-module `blit_addr_gen` holds the col/row counters, source index, destination row base and in-bounds flag. It advances on an `step` input and flags `last`. The FSM and the write-pipeline registers stay in `sprite_blitter`.

## Test plan
- Basic: 4x3 blit, `src_base`=100, dst (10,20). Expect reads at 100..111. Expect 12 writes; first address 6410, addresses 6410..6413, 6730..6733, 7050..7053, data matching source; `done` at N+15.
- Right clip: `src_w`=4, `dst_x`=318, `dst_y`=0, `src_h`=1. Expect writes only to 318 and 319; `fb_we`=0 for cols 2 and 3; `done` at N+7.
- Zero size: `src_w`=0. Expect `done` at N+1, `busy` never high, no `fb_we`.
- Transparency (macro defined): 2x1 sprite, values {0, 7}. Expect only the second pixel written, with value 7. Without the macro, both are written.
- Reset mid-blit: assert `Reset_n`=0 during RUN. Expect all outputs 0 at once, no write after release, and a fresh `start` working normally.
- Busy-ignore: pulse `start` with new geometry at N+3 of an 8x8 blit. Expect the original blit to complete unchanged and the second request to be dropped.
